// File: rtl/fpcvt_arbiter.sv
// Two-channel round-robin front end for a single 12-bit integer to 8-bit
// floating-point converter; one result is held at a time on a valid/ready output.

module fpcvt (
    input  logic [11:0] d,
    output logic        s,
    output logic [2:0]  e,
    output logic [3:0]  f
);
    logic [11:0] mag;
    logic [3:0]  lead;
    logic [3:0]  e_raw;
    logic [3:0]  f_raw;
    logic        rnd;
    logic [4:0]  f_sum;
    logic [3:0]  e_adj;

    always_comb begin
        s     = d[11];
        mag   = d[11] ? (~d + 12'd1) : d;
        lead  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) lead = 4'(i);
        end
        // Significand is the four bits starting at the leading one.
        e_raw = (lead > 4'd3) ? (lead - 4'd3) : 4'd0;
        f_raw = 4'(mag >> e_raw);
        rnd   = (e_raw != 4'd0) && ((mag & (12'd1 << (e_raw - 4'd1))) != 12'd0);
        f_sum = {1'b0, f_raw} + {4'd0, rnd};
        e_adj = e_raw;
        f     = f_sum[3:0];
        if (f_sum[4]) begin
            f     = 4'd8;
            e_adj = e_raw + 4'd1;
        end
        e = e_adj[2:0];
        // Only -2048 and values rounding past 15*2^7 land here.
        if (e_adj > 4'd7) begin
            e = 3'd7;
            f = 4'd15;
        end
    end
endmodule

module fpcvt_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [11:0]      in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [11:0]      in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_s,
    output logic [2:0]       out_e,
    output logic [3:0]       out_f,
    output logic             out_src,
    output logic             busy,
    output logic [CNT_W-1:0] conv_count,
    output logic [1:0]       dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on data, and producers hold data while waiting.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        rr;
    logic [11:0] d_q;
    logic        src_q;
    logic        grant0, grant1, grant;
    logic        cv_s;
    logic [2:0]  cv_e;
    logic [3:0]  cv_f;

    fpcvt u_fpcvt (
        .d (d_q),
        .s (cv_s),
        .e (cv_e),
        .f (cv_f)
    );

    // rr names the channel that wins when both request.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            grant0 = in0_valid && (!in1_valid || !rr);
            grant1 = in1_valid && (!in0_valid ||  rr);
        end
    end

    assign grant     = grant0 | grant1;
    assign in0_ready = grant0;
    assign in1_ready = grant1;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant) state_nxt = CONV;
            end
            CONV: state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= 1'b0;
            d_q        <= 12'd0;
            src_q      <= 1'b0;
            out_s      <= 1'b0;
            out_e      <= 3'd0;
            out_f      <= 4'd0;
            out_src    <= 1'b0;
            conv_count <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                d_q   <= grant1 ? in1_data : in0_data;
                src_q <= grant1;
                rr    <= grant0;
            end
            if (state == CONV) begin
                out_s   <= cv_s;
                out_e   <= cv_e;
                out_f   <= cv_f;
                out_src <= src_q;
            end
            if (out_valid && out_ready) conv_count <= conv_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Directed and randomized checks of fpcvt_arbiter against a value-level
// converter model and a round-robin transaction model.

module tb_fpcvt_arbiter;
    localparam int CNT_W = 4;
    localparam int PERIOD = 10;

    logic             clk;
    logic             rst;
    logic             in0_valid, in1_valid;
    logic [11:0]      in0_data, in1_data;
    logic             in0_ready, in1_ready;
    logic             out_valid, out_ready;
    logic             out_s;
    logic [2:0]       out_e;
    logic [3:0]       out_f;
    logic             out_src;
    logic             busy;
    logic [CNT_W-1:0] conv_count;
    logic [1:0]       dbg_state;

    fpcvt_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in0_valid  (in0_valid),
        .in0_data   (in0_data),
        .in0_ready  (in0_ready),
        .in1_valid  (in1_valid),
        .in1_data   (in1_data),
        .in1_ready  (in1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_e      (out_e),
        .out_f      (out_f),
        .out_src    (out_src),
        .busy       (busy),
        .conv_count (conv_count),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    // Scoreboard and model state
    logic [8:0]  exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          rr_m = 0;
    int          cnt_m = 0;
    logic        pend0, pend1;
    logic [11:0] pdat0, pdat1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    endtask

    // Value = F * 2^E, F rounded half-up, saturating at 15 * 2^7.
    function automatic logic [7:0] fp_ref(input logic [11:0] d);
        int v, mag, e, f;
        v   = int'($signed(d));
        mag = (v < 0) ? -v : v;
        e   = 0;
        while ((mag >> e) >= 16) e++;
        if (e == 0) f = mag;
        else        f = (mag + (1 << (e - 1))) >> e;
        if (f == 16) begin
            f = 8;
            e++;
        end
        if (e > 7) begin
            e = 7;
            f = 15;
        end
        return {v < 0, 3'(e), 4'(f)};
    endfunction

    // Driver tasks
    task automatic do_reset();
        rst       = 1'b1;
        in0_valid = 1'b1;
        in0_data  = 12'd5;
        in1_valid = 1'b1;
        in1_data  = 12'd9;
        out_ready = 1'b1;
        #1;
        check("rst_ready0", in0_ready, 0);
        check("rst_ready1", in1_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ready0_b", in0_ready, 0);
        check("rst_outv", out_valid, 0);
        check("rst_fields", {out_src, out_s, out_e, out_f}, 0);
        check("rst_busy", busy, 0);
        check("rst_count", conv_count, 0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        pend0     = 1'b0;
        pend1     = 1'b0;
        rr_m      = 0;
        cnt_m     = 0;
        exp_q.delete();
    endtask

    // One full transaction from the pending producers; returns the grant edge time.
    task automatic run_conv(input int stall, input bit ready_early, output longint gtime);
        int         win;
        logic [8:0] want;
        in0_valid = pend0;
        in0_data  = pdat0;
        in1_valid = pend1;
        in1_data  = pdat1;
        out_ready = 1'b0;
        #1;
        if (pend0 && pend1) win = rr_m;
        else                win = pend1 ? 1 : 0;
        rr_m = 1 - win;
        exp_q.push_back({win[0], fp_ref(win == 1 ? pdat1 : pdat0)});
        check("grant_ready0", in0_ready, win == 0);
        check("grant_ready1", in1_ready, win == 1);
        @(posedge clk);
        gtime = $time;
        #1;
        if (win == 0) begin
            pend0 = 1'b0;
            in0_valid = 1'b0;
        end else begin
            pend1 = 1'b0;
            in1_valid = 1'b0;
        end
        out_ready = ready_early;
        check("conv_busy", busy, 1);
        check("conv_outv", out_valid, 0);
        check("conv_ready", {in1_ready, in0_ready}, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        want = exp_q.pop_front();
        for (int k = 0; k <= stall; k++) begin
            check("hold_outv", out_valid, 1);
            check("hold_result", {out_src, out_s, out_e, out_f}, want);
            check("hold_busy", busy, 1);
            check("hold_ready", {in1_ready, in0_ready}, 0);
            if (k == stall) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
        check("done_outv", out_valid, 0);
        check("done_busy", busy, 0);
        check("done_count", conv_count, cnt_m);
    endtask

    initial begin
        longint g, g_prev;
        rst = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data = '0;
        in1_data = '0;
        out_ready = 1'b0;
        pdat0 = '0;
        pdat1 = '0;

        // Single request on channel 0
        do_reset();
        pend0 = 1'b1;
        pdat0 = 12'd422;
        run_conv(0, 1'b0, g);

        // Both channels continuously valid: grants alternate starting with 0
        do_reset();
        pend0 = 1'b1;
        pdat0 = 12'd125;
        pend1 = 1'b1;
        pdat1 = 12'h800;
        for (int i = 0; i < 4; i++) begin
            run_conv(0, 1'b0, g);
            check("alt_src", {31'd0, out_src}, i % 2);
            pend0 = 1'b1;
            pend1 = 1'b1;
        end

        // Zero on channel 1 with ten cycles of backpressure
        pend0 = 1'b0;
        pend1 = 1'b1;
        pdat1 = 12'h000;
        run_conv(10, 1'b0, g);

        // Reset while in CONV discards the sample
        in1_valid = 1'b1;
        in1_data  = 12'hFFF;
        #1;
        check("midrst_grant", in1_ready, 1);
        @(posedge clk); #1;
        in1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pend0 = 1'b0;
        pend1 = 1'b0;
        rr_m = 0;
        cnt_m = 0;
        for (int k = 0; k < 4; k++) begin
            check("midrst_outv", out_valid, 0);
            check("midrst_busy", busy, 0);
            check("midrst_fields", {out_src, out_s, out_e, out_f}, 0);
            check("midrst_count", conv_count, 0);
            @(posedge clk); #1;
        end

        // Randomized producers, data and backpressure
        for (int i = 0; i < 24; i++) begin
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                pend0 = 1'b1;
                pdat0 = 12'($urandom);
            end
            if (!pend1 && $urandom_range(0, 1) == 1) begin
                pend1 = 1'b1;
                pdat1 = 12'($urandom);
            end
            if (!pend0 && !pend1) begin
                pend0 = 1'b1;
                pdat0 = 12'($urandom);
            end
            run_conv($urandom_range(0, 3), 1'($urandom_range(0, 1)), g);
        end

        // Seventeen back-to-back conversions wrap the 4-bit counter to 1
        do_reset();
        g_prev = 0;
        for (int i = 0; i < 17; i++) begin
            if (!pend0) begin
                pend0 = 1'b1;
                pdat0 = 12'($urandom);
            end
            if (!pend1) begin
                pend1 = 1'b1;
                pdat1 = 12'($urandom);
            end
            run_conv(0, 1'b1, g);
            if (i > 0) check("spacing", 32'((g - g_prev) / PERIOD), 3);
            g_prev = g;
        end
        check("wrap_count", conv_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
